// File: rtl/t03_fetch_pkg.sv
// Shared types and constants for the t03 instruction fetch unit.
// T03_FETCH_PREFETCH_EN adds the prefetch states to fetch_state_t.
package t03_fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    localparam logic [1:0] WORD_OFS = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL
`ifdef T03_FETCH_PREFETCH_EN
        ,
        PF_REQ,
        PF_FILL
`endif
    } fetch_state_t;

endpackage

// File: rtl/t03_fetch_mem_port.sv
// Single-outstanding request/acknowledge read port to external memory.
// Holds mem_req/mem_addr until mem_ack, then captures the returned word.
module t03_fetch_mem_port
    import t03_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] rdata,
    output logic              done
);

    // An ack only counts while a request is actually outstanding.
    assign done = mem_req & mem_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            rdata    <= '0;
        end else if (done) begin
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
        end else if (start && !mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {start_addr[ADDR_W-1:2], WORD_OFS};
        end
    end

endmodule

// File: rtl/t03_fetch_unit.sv
// Instruction fetch controller: cache lookup, miss fill from memory.
// Define T03_FETCH_PREFETCH_EN to prefetch next_pc while idle.
module t03_fetch_unit
    import t03_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              stall_in,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [ADDR_W-1:0] cache_next_addr,
    input  logic              cache_hit,
    input  logic              cache_next_hit,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              cache_fill,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_stall
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] req_addr;
    logic              latch_req;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [DATA_W-1:0] port_data;
    logic              port_done;

`ifdef T03_FETCH_PREFETCH_EN
    logic [ADDR_W-1:0] pf_addr;
    logic              latch_pf;
    logic              pf_go;

    assign pf_go = !stall_in && !cache_next_hit &&
                   (next_pc[ADDR_W-1:2] != pc[ADDR_W-1:2]);
`else
    logic unused_inputs;

    assign unused_inputs = ^{stall_in, cache_next_hit};
`endif

    assign cache_next_addr = next_pc;
    assign fetch_stall     = !instr_valid;

    t03_fetch_mem_port #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem_port (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .rdata     (port_data),
        .done      (port_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_addr <= '0;
`ifdef T03_FETCH_PREFETCH_EN
            pf_addr  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (latch_req) begin
                req_addr <= pc;
            end
`ifdef T03_FETCH_PREFETCH_EN
            if (latch_pf) begin
                pf_addr <= next_pc;
            end
`endif
        end
    end

    // Outputs are held at their reset values while rst is low.
    always_comb begin
        state_d     = state_q;
        latch_req   = 1'b0;
        start       = 1'b0;
        start_addr  = pc;
        cache_addr  = pc;
        cache_fill  = 1'b0;
        cache_wdata = '0;
        instr       = '0;
        instr_valid = 1'b0;
`ifdef T03_FETCH_PREFETCH_EN
        latch_pf    = 1'b0;
`endif
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (cache_hit) begin
                        instr       = cache_rdata;
                        instr_valid = 1'b1;
`ifdef T03_FETCH_PREFETCH_EN
                        if (pf_go) begin
                            state_d    = PF_REQ;
                            start      = 1'b1;
                            start_addr = next_pc;
                            latch_pf   = 1'b1;
                        end
`endif
                    end else begin
                        state_d   = REQ;
                        start     = 1'b1;
                        latch_req = 1'b1;
                    end
                end
                REQ: begin
                    if (port_done) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    cache_addr  = req_addr;
                    cache_fill  = 1'b1;
                    cache_wdata = port_data;
                    instr       = port_data;
                    instr_valid = (pc[ADDR_W-1:2] == req_addr[ADDR_W-1:2]);
                    state_d     = IDLE;
                end
`ifdef T03_FETCH_PREFETCH_EN
                PF_REQ: begin
                    if (port_done) begin
                        state_d = PF_FILL;
                    end
                end
                PF_FILL: begin
                    cache_addr  = pf_addr;
                    cache_fill  = 1'b1;
                    cache_wdata = port_data;
                    state_d     = IDLE;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t03_fetch_unit.sv
// Self-checking bench for t03_fetch_unit with a behavioural cache and memory.
// Prefetch checks are built only when T03_FETCH_PREFETCH_EN is defined.
module tb_t03_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] next_pc = '0;
    logic        stall_in = 1'b0;
    logic [31:0] cache_addr;
    logic [31:0] cache_next_addr;
    logic        cache_hit;
    logic        cache_next_hit;
    logic [31:0] cache_rdata;
    logic        cache_fill;
    logic [31:0] cache_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_stall;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment cache: 256 words, ignores zero writes.
    logic [31:0] cmem [256];
    logic        cval [256];
    logic        cclr = 1'b1;

    // Expected cache contents, maintained from the rules alone.
    logic [31:0] ref_data [256];
    logic        ref_val  [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cclr) begin
            for (int i = 0; i < 256; i++) cval[i] <= 1'b0;
        end else if (cache_fill && cache_wdata != 32'h0) begin
            cmem[cache_addr[9:2]] <= cache_wdata;
            cval[cache_addr[9:2]] <= 1'b1;
        end
    end

    assign cache_hit      = cval[cache_addr[9:2]] && (cache_addr[31:10] == 0);
    assign cache_rdata    = cmem[cache_addr[9:2]];
    assign cache_next_hit = cval[cache_next_addr[9:2]] &&
                            (cache_next_addr[31:10] == 0);

    t03_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .next_pc        (next_pc),
        .stall_in       (stall_in),
        .cache_addr     (cache_addr),
        .cache_next_addr(cache_next_addr),
        .cache_hit      (cache_hit),
        .cache_next_hit (cache_next_hit),
        .cache_rdata    (cache_rdata),
        .cache_fill     (cache_fill),
        .cache_wdata    (cache_wdata),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .fetch_stall    (fetch_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] a);
        pc      = a;
        next_pc = a;
        #1;
    endtask

    // Expect a 0-latency hit in IDLE, then advance one cycle.
    task automatic hit_chk(input logic [31:0] a);
        set_pc(a);
        chk("hit_valid", {31'h0, instr_valid}, 32'h1);
        chk("hit_instr", instr, ref_data[a[9:2]]);
        chk("hit_stall", {31'h0, fetch_stall}, 32'h0);
        tick();
    endtask

    // Miss at cycle 0, request from cycle 1, ack after lat extra cycles.
    task automatic miss(input logic [31:0] a, input logic [31:0] d,
                        input int lat, input bit redir,
                        input logic [31:0] rpc, input bit st);
        logic [31:0] aligned;
        logic        exp_v;
        aligned  = {a[31:2], 2'b00};
        stall_in = st;
        set_pc(a);
        chk("miss_valid", {31'h0, instr_valid}, 32'h0);
        chk("miss_req0", {31'h0, mem_req}, 32'h0);
        tick();
        chk("req_rise", {31'h0, mem_req}, 32'h1);
        chk("req_addr", mem_addr, aligned);
        if (redir) begin
            pc      = rpc;
            next_pc = rpc;
        end
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("req_hold", {31'h0, mem_req}, 32'h1);
            chk("req_hold_valid", {31'h0, instr_valid}, 32'h0);
        end
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        #1;
        exp_v = (pc[31:2] == a[31:2]);
        chk("fill_en", {31'h0, cache_fill}, 32'h1);
        chk("fill_addr", {cache_addr[31:2], 2'b00}, aligned);
        chk("fill_data", cache_wdata, d);
        chk("fill_instr", instr, d);
        chk("fill_valid", {31'h0, instr_valid}, {31'h0, exp_v});
        chk("fill_req_low", {31'h0, mem_req}, 32'h0);
        if (d != 32'h0) begin
            ref_val[a[9:2]]  = 1'b1;
            ref_data[a[9:2]] = d;
        end
        tick();
        stall_in = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 256; i++) begin
            ref_val[i]  = 1'b0;
            ref_data[i] = '0;
        end

        // Reset with ack toggling underneath.
        for (int i = 0; i < 2; i++) begin
            mem_ack   = ~mem_ack;
            mem_rdata = $urandom;
            tick();
            chk("rst_req", {31'h0, mem_req}, 32'h0);
            chk("rst_valid", {31'h0, instr_valid}, 32'h0);
            chk("rst_fill", {31'h0, cache_fill}, 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_addr", mem_addr, 32'h0);
        end
        mem_ack = 1'b0;
        cclr    = 1'b0;
        rst     = 1'b1;

        // Cold miss, ack 3 cycles after request, then hit.
        miss(32'h40, 32'h0050_0093, 3, 1'b0, 32'h0, 1'b0);
        hit_chk(32'h40);

        // Zero word: delivered once, re-fetched on the next visit.
        miss(32'h80, 32'h0, 1, 1'b0, 32'h0, 1'b0);
        miss(32'h80, 32'h0, 0, 1'b0, 32'h0, 1'b0);

        // Redirect during REQ.
        d = $urandom | 32'h1;
        miss(32'h100, d, 2, 1'b1, 32'h200, 1'b0);
        miss(32'h200, $urandom | 32'h1, 1, 1'b0, 32'h0, 1'b0);
        hit_chk(32'h100);
        hit_chk(32'h200);

        // Delivery under stall is not lost.
        miss(32'h140, $urandom | 32'h1, 0, 1'b0, 32'h0, 1'b1);
        hit_chk(32'h140);

        // Stray ack in IDLE is ignored.
        set_pc(32'h40);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("stray_req", {31'h0, mem_req}, 32'h0);
        chk("stray_fill", {31'h0, cache_fill}, 32'h0);
        hit_chk(32'h40);

        // Reset mid-request, coinciding with ack.
        set_pc(32'h300);
        tick();
        chk("mr_req", {31'h0, mem_req}, 32'h1);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        pc        = 32'h40;
        next_pc   = 32'h40;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_req_low", {31'h0, mem_req}, 32'h0);
        chk("mr_fill", {31'h0, cache_fill}, 32'h0);
        chk("mr_hit", {31'h0, instr_valid}, 32'h1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("mr_late_req", {31'h0, mem_req}, 32'h0);
        chk("mr_late_fill", {31'h0, cache_fill}, 32'h0);
        chk("mr_not_cached", {31'h0, cval[8'hC0]}, 32'h0);
        tick();
        miss(32'h300, $urandom | 32'h1, 1, 1'b0, 32'h0, 1'b0);
        hit_chk(32'h300);

        // Randomized fetches over a small address window.
        for (int it = 0; it < 40; it++) begin
            a = {20'h0, 4'h0, $urandom_range(16, 47) & 8'hFF, 2'b00};
            if (ref_val[a[9:2]]) begin
                stall_in = $urandom_range(0, 1) == 1;
                hit_chk(a);
                stall_in = 1'b0;
            end else begin
                d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                miss(a, d, $urandom_range(0, 3), 1'b0, 32'h0,
                     $urandom_range(0, 1) == 1);
            end
        end

`ifdef T03_FETCH_PREFETCH_EN
        // Prefetch of next_pc while hitting on pc.
        miss(32'h0, $urandom | 32'h1, 0, 1'b0, 32'h0, 1'b0);
        pc      = 32'h0;
        next_pc = 32'h4;
        #1;
        chk("pf_hit", {31'h0, instr_valid}, 32'h1);
        tick();
        chk("pf_req", {31'h0, mem_req}, 32'h1);
        chk("pf_addr", mem_addr, 32'h4);
        chk("pf_req_valid", {31'h0, instr_valid}, 32'h0);
        d         = $urandom | 32'h1;
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("pf_fill", {31'h0, cache_fill}, 32'h1);
        chk("pf_fill_addr", cache_addr, 32'h4);
        chk("pf_fill_data", cache_wdata, d);
        chk("pf_fill_valid", {31'h0, instr_valid}, 32'h0);
        ref_val[1]  = 1'b1;
        ref_data[1] = d;
        tick();
        hit_chk(32'h4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t03_fetch_unit.md
# t03_fetch_unit

Instruction fetch controller between the program counter, `t03_instruction_cache`, and the external memory interface. Each cycle it looks up the current PC in the cache and, on a hit, hands the cached word to decode. On a miss it runs a single-outstanding request/acknowledge read to memory, writes the returned word into the cache, and forwards it to decode in the same cycle. An optional prefetcher fills the cache line for the next PC while the unit is otherwise idle.

## Interface
Parameters:
- `ADDR_W`, 32, address width (word-aligned byte addresses; bits [1:0] ignored)
- `DATA_W`, 32, instruction width

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-low reset (reset when 0 at a rising edge)
- `pc`  in  32  address of the instruction decode wants now
- `next_pc`  in  32  predicted next address (prefetch candidate)
- `stall_in`  in  1  downstream freeze; an instruction is not consumed while high
- `cache_addr`  out  32  drives cache `current_address`
- `cache_next_addr`  out  32  drives cache `next_address`; equals `next_pc`
- `cache_hit`  in  1  cache `hit` for `cache_addr`
- `cache_next_hit`  in  1  cache `next_hit`
- `cache_rdata`  in  32  cache `cache_out`
- `cache_fill`  out  1  drives cache `cache_read` (write enable)
- `cache_wdata`  out  32  drives cache `input_instruction`
- `mem_req`  out  1  memory read request
- `mem_addr`  out  32  memory read address, word-aligned
- `mem_ack`  in  1  read data valid, one-cycle pulse
- `mem_rdata`  in  32  read data, qualified by `mem_ack`
- `instr`  out  32  instruction to decode
- `instr_valid`  out  1  `instr` belongs to the current `pc`
- `fetch_stall`  out  1  equals `!instr_valid`; stalls the PC

## Operation
- States: IDLE, REQ, FILL, PF_REQ, PF_FILL. Reset state is IDLE.
- Reset values: `mem_req`=0, `mem_addr`=0, `cache_fill`=0, `cache_wdata`=0, `instr`=0, `instr_valid`=0, captured data register = 0.
- IDLE: `cache_addr`=`pc`.
  - If `cache_hit`: `instr`=`cache_rdata` and `instr_valid`=1, combinationally.
  - Otherwise latch `req_addr`=`pc` and go to REQ.
- REQ: `mem_req`=1 and `mem_addr`=`req_addr`, both held until `mem_ack`. On `mem_ack`, capture `mem_rdata` and go to FILL.
- FILL (exactly one cycle): `cache_addr`=`req_addr`, `cache_fill`=1, `cache_wdata`=captured data.
  - `instr`=captured data and `instr_valid`=(`pc`==`req_addr`).
  - Next state is IDLE.
- Zero word: the cache ignores an all-zero `input_instruction`. A zero word is still delivered from the capture register in FILL and is never cached. Each later fetch of that address misses again; this is required behaviour.
- PC change during REQ (branch redirect): the outstanding request completes normally and the line is filled. `instr_valid` stays 0 in FILL because the address no longer matches, and the unit returns to IDLE.
- `stall_in`: the state machine still progresses. A word delivered in FILL while `stall_in`=1 is not lost: the next IDLE cycle hits in the cache, except for a zero word, which re-fetches.
- `mem_ack` outside REQ/PF_REQ is ignored.
- Simultaneous `mem_ack` and `rst`=0: reset wins, and the data is dropped.

## Timing
- Hit: 0-cycle latency. `instr_valid` is high in the same cycle `pc` is presented.
- Miss, with the miss detected in cycle 0:
  - `mem_req` rises in cycle 1.
  - With an ack in cycle k, FILL occurs in cycle k+1.
  - Minimum miss penalty is 2 cycles (ack in cycle 1, data in cycle 2).
- The cache line holds the new word from cycle k+2. `instr_valid` is high for one FILL cycle, then comes from the hit path.
- Reset mid-request: `mem_req` is low in the cycle after `rst` is sampled low. The memory side must tolerate an abandoned request.

## Configuration
- `T03_FETCH_PREFETCH_EN` defined:
  - In IDLE with `cache_hit`=1, `stall_in`=0, `cache_next_hit`=0 and `next_pc`≠`pc`, latch `pf_addr`=`next_pc` and enter PF_REQ.
  - PF_REQ mirrors REQ using `pf_addr`. While in PF_REQ or PF_FILL, `instr_valid`=0.
  - PF_FILL writes the cache at `pf_addr`, then the unit returns to IDLE.
  - A demand miss cannot start until the prefetch completes.
- Not defined: PF states are absent, and the unit only fetches on demand.

## Structure
- Package `t03_fetch_pkg`: state enum `fetch_state_t`, `ADDR_W`/`DATA_W` defaults, word-offset constant 2'b00.
- One sub-module, `t03_fetch_mem_port`: the request/ack handshake (holds `mem_req`/`mem_addr`, captures data on ack), shared by demand and prefetch paths.

## Test plan
- Reset: `rst`=0 for 2 cycles with `mem_ack` toggling -> `mem_req`=0, `instr_valid`=0, `cache_fill`=0.
- Cold miss: `pc`=0x40, empty cache, `mem_rdata`=0x00500093 acked 3 cycles after `mem_req` rises -> FILL with `cache_fill`=1, `instr`=0x00500093, `instr_valid`=1; the next cycle hits with 0 latency.
- Zero word: `pc`=0x80, `mem_rdata`=0 -> delivered once in FILL; a second visit to 0x80 re-issues `mem_req`.
- Redirect: miss on 0x100, `pc` changed to 0x200 during REQ -> FILL writes 0x100, `instr_valid`=0, then a new request for 0x200.
- Mid-request reset: `rst`=0 during REQ -> `mem_req` is 0 the next cycle, and a later ack is ignored.
- Prefetch (macro on): hit on `pc`=0x0, `next_pc`=0x4 not cached -> PF_REQ with `mem_addr`=0x4; after fill, `pc`=0x4 hits immediately.
